// File: rtl/vp_irq_pkg.sv
// vp_irq_pkg: shared constants for the VProc interrupt controller.
//   - register indices as decoded from Addr[4:2]
//   - TCTRL bit positions
//   - ACTIVE valid bit position
package vp_irq_pkg;

  localparam logic [2:0] REG_RAW     = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_MASK    = 3'd2;
  localparam logic [2:0] REG_EDGE    = 3'd3;
  localparam logic [2:0] REG_TLOAD   = 3'd4;
  localparam logic [2:0] REG_TCTRL   = 3'd5;
  localparam logic [2:0] REG_TCOUNT  = 3'd6;
  localparam logic [2:0] REG_ACTIVE  = 3'd7;

  localparam int TCTRL_EN       = 0;
  localparam int TCTRL_PERIODIC = 1;

  localparam int ACTIVE_VALID = 31;

endpackage

// File: rtl/vp_irq_timer.sv
// vp_irq_timer: down-counting timer with terminal-count compare.
// Ports:
//   clk, nreset          clock, async active-low reset
//   wr_tload, wr_tctrl   one-cycle write strobes from the bus decode
//   wdata                write data
//   tload, tctrl, tcount register read-back values
//   expire               high in the cycle the running counter sits at 0
module vp_irq_timer
  import vp_irq_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        wr_tload,
  input  logic        wr_tctrl,
  input  logic [31:0] wdata,
  output logic [31:0] tload,
  output logic [1:0]  tctrl,
  output logic [31:0] tcount,
  output logic        expire
);

  logic en;
  logic periodic;

  assign expire = en & (tcount == 32'd0);

  always_comb begin
    tctrl                 = '0;
    tctrl[TCTRL_EN]       = en;
    tctrl[TCTRL_PERIODIC] = periodic;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tload    <= '0;
      tcount   <= '0;
      en       <= 1'b0;
      periodic <= 1'b0;
    end else begin
      if (wr_tload) tload <= wdata;
      if (en) begin
        if (tcount == 32'd0) begin
          if (periodic) tcount <= tload;
          else          en     <= 1'b0;
        end else begin
          tcount <= tcount - 32'd1;
        end
      end
      // A TCTRL write overrides the tick; only an EN 0->1 edge reloads,
      // so rewriting PERIODIC on a running timer does not restart it.
      if (wr_tctrl) begin
        en       <= wdata[TCTRL_EN];
        periodic <= wdata[TCTRL_PERIODIC];
        if (wdata[TCTRL_EN] && !en) tcount <= tload;
      end
    end
  end

endmodule

// File: rtl/vp_irq_ctrl.sv
// vp_irq_ctrl: memory-mapped interrupt controller with timer for a VProc node.
// Ports:
//   clk, nreset               clock, async active-low reset
//   CS, Addr, WE, RD, DataOut VProc bus request (Addr[4:2] selects register)
//   DataIn, WRAck, RDAck      VProc bus response, one-cycle acks
//   irq_src                   external interrupt sources (synchronous)
//   Interrupt                 {0.., timer_irq, ext_irq}
module vp_irq_ctrl
  import vp_irq_pkg::*;
#(
  parameter int N_SRC     = 8,
  parameter int INT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 CS,
  input  logic [31:0]          Addr,
  input  logic                 WE,
  input  logic                 RD,
  input  logic [31:0]          DataOut,
  output logic [31:0]          DataIn,
  output logic                 WRAck,
  output logic                 RDAck,
  input  logic [N_SRC-1:0]     irq_src,
  output logic [INT_WIDTH-1:0] Interrupt
);

  logic             access, wr, rd;
  logic [2:0]       reg_sel;
  logic [N_SRC-1:0] raw_q, raw_prev, edge_mode, rise;
  logic [N_SRC:0]   pending, mask, w1c, pend_next, act;
  logic [31:0]      tload, tcount, rdata;
  logic [1:0]       tctrl;
  logic             expire;
  logic             act_valid;
  logic [4:0]       act_idx;
  logic             ext_irq, timer_irq;
  logic             unused_addr;

  assign unused_addr = ^{Addr[31:5], Addr[1:0]};

  // Requiring both acks low before accepting means a held strobe completes
  // once every two cycles. WE wins when both strobes are high.
  assign access  = CS & (WE | RD) & ~WRAck & ~RDAck;
  assign wr      = access & WE;
  assign rd      = access & ~WE;
  assign reg_sel = Addr[4:2];

  assign w1c  = (wr && reg_sel == REG_PENDING) ? DataOut[N_SRC:0] : '0;
  assign rise = raw_q & ~raw_prev;

  // Level sources simply mirror the sampled input, so W1C cannot stick;
  // for edge sources and the timer a new event outranks a same-cycle clear.
  always_comb begin
    pend_next = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pend_next[i] = edge_mode[i] ? ((pending[i] & ~w1c[i]) | rise[i]) : raw_q[i];
    end
    pend_next[N_SRC] = (pending[N_SRC] & ~w1c[N_SRC]) | expire;
  end

  assign act = pending & mask;

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    act_valid = 1'b0;
    act_idx   = '0;
    for (int i = N_SRC; i >= 0; i--) begin
      if (act[i]) begin
        act_valid = 1'b1;
        act_idx   = 5'(i);
      end
    end
  end

  assign ext_irq   = |act[N_SRC-1:0];
  assign timer_irq = act[N_SRC];

  always_comb begin
    Interrupt    = '0;
    Interrupt[0] = ext_irq;
    Interrupt[1] = timer_irq;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_RAW:     rdata = 32'(raw_q);
      REG_PENDING: rdata = 32'(pending);
      REG_MASK:    rdata = 32'(mask);
      REG_EDGE:    rdata = 32'(edge_mode);
      REG_TLOAD:   rdata = tload;
      REG_TCTRL:   rdata = 32'(tctrl);
      REG_TCOUNT:  rdata = tcount;
      REG_ACTIVE: begin
        rdata[ACTIVE_VALID] = act_valid;
        rdata[4:0]          = act_idx;
      end
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      WRAck  <= 1'b0;
      RDAck  <= 1'b0;
      DataIn <= '0;
    end else begin
      WRAck  <= wr;
      RDAck  <= rd;
      DataIn <= rd ? rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      raw_q     <= '0;
      raw_prev  <= '0;
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '0;
    end else begin
      raw_q    <= irq_src;
      raw_prev <= raw_q;
      pending  <= pend_next;
      if (wr && reg_sel == REG_MASK) mask      <= DataOut[N_SRC:0];
      if (wr && reg_sel == REG_EDGE) edge_mode <= DataOut[N_SRC-1:0];
    end
  end

  vp_irq_timer u_timer (
    .clk      (clk),
    .nreset   (nreset),
    .wr_tload (wr && reg_sel == REG_TLOAD),
    .wr_tctrl (wr && reg_sel == REG_TCTRL),
    .wdata    (DataOut),
    .tload    (tload),
    .tctrl    (tctrl),
    .tcount   (tcount),
    .expire   (expire)
  );

endmodule

// File: doc/vp_irq_ctrl.md
# vp_irq_ctrl

Memory-mapped interrupt controller with an integrated down-counting timer, sitting on a VProc node's bus and driving that node's `Interrupt` input. VProc user code programs mask, sense mode and timer, then services interrupts by reading `ACTIVE` and writing `PENDING` to clear. It replaces the ad-hoc random interrupt generation in top-level test environments with a deterministic, software-controlled source.

## Interface
- `N_SRC`, 8: number of external interrupt sources (1–31).
- `INT_WIDTH`, 3: width of `Interrupt` output, matching the VProc `INT_WIDTH` (at least 2).
- `clk`  in  1: clock; all logic on rising edge.
- `nreset`  in  1: asynchronous, active-low reset.
- `CS`  in  1: chip select, decoded externally from `Addr[31:28]`.
- `Addr`  in  32: VProc byte address; `Addr[4:2]` selects the register.
- `WE`  in  1: VProc write strobe, held until `WRAck`.
- `RD`  in  1: VProc read strobe, held until `RDAck`.
- `DataOut`  in  32: VProc write data.
- `DataIn`  out  32: read data to VProc.
- `WRAck`  out  1: write acknowledge.
- `RDAck`  out  1: read acknowledge.
- `irq_src`  in  N_SRC: external sources, synchronous to `clk`.
- `Interrupt`  out  INT_WIDTH: `{0…, timer_irq, ext_irq}`.

## Operation
- Register map (offsets):
  - 0x00 `RAW`: RO, registered `irq_src`.
  - 0x04 `PENDING`: R/W1C, bit N_SRC is the timer.
  - 0x08 `MASK`: RW, 1 = enabled.
  - 0x0C `EDGE`: RW, 1 = rising-edge, 0 = level.
  - 0x10 `TLOAD`: RW, 32-bit.
  - 0x14 `TCTRL`: RW, bit0 EN, bit1 PERIODIC.
  - 0x18 `TCOUNT`: RO.
  - 0x1C `ACTIVE`: RO, bit31 valid, [4:0] lowest index with PENDING&MASK set.
- Unused bits read 0; unmapped offsets read 0, writes ignored but acked.
- Level source: PENDING bit follows registered source each cycle. W1C has no lasting effect while the source is high.
- Edge source: set on registered 0→1. Set has priority over a same-cycle W1C.
- Timer: a write to TCTRL with EN 0→1 loads TCOUNT from TLOAD. While EN is set, TCOUNT decrements. At TCOUNT==0, PENDING[N_SRC] is set. PERIODIC reloads from TLOAD; one-shot clears EN. TLOAD=0 periodic sets pending every cycle.
- `ext_irq` = |(PENDING[N_SRC-1:0] & MASK); `timer_irq` = PENDING[N_SRC] & MASK[N_SRC].
- Priority: lowest index wins; the timer is lowest priority.

## Timing
- Reset values: all registers 0, `DataIn`=0, `WRAck`=`RDAck`=0, `Interrupt`=0, TCOUNT=0.
- Access: the cycle after `CS&(WE|RD)` is seen with the ack low, the ack is asserted for exactly one cycle. Register write takes effect on the same edge the ack rises. `DataIn` is valid while `RDAck` is high and returns to 0 after.
- An ack never asserts on two consecutive cycles, so a held strobe completes once per two cycles.
- `WE` and `RD` both high selects write only.
- Source-to-PENDING latency: 2 cycles (sampling register, then pending). PENDING-to-`Interrupt`: combinational.
- Reset mid-access: ack drops immediately and the transaction is lost. VProc reissues it.

## Structure
- Package `vp_irq_pkg`: register offset localparams, TCTRL bit positions, ACTIVE valid bit position.
- Sub-module `vp_irq_timer`: TLOAD/TCTRL/TCOUNT and the expiry pulse. Top level holds bus decode, source registers, pending/mask logic and the priority encoder.

## Test plan
- Reset: `nreset`=0 mid-read → `RDAck`=0, `Interrupt`=0, all registers read 0 after release.
- Edge: EDGE=0x01, MASK=0x01, pulse `irq_src[0]` one cycle → `Interrupt[0]`=1 two cycles later. Write PENDING=0x01 → `Interrupt[0]`=0.
- Level: MASK=0x04, hold `irq_src[2]` high, W1C PENDING → reads back 0x04. Drop source → reads 0.
- Priority: pending 0x0A, MASK=0xFF → ACTIVE=0x80000001. Clear bit1 → ACTIVE=0x80000003.
- Timer: TLOAD=5, TCTRL=0x3, MASK bit N_SRC set → `Interrupt[1]` rises every 6 cycles. One-shot (0x1) → fires once, TCTRL reads 0.
- Collision: edge on source 3 in the same cycle as a W1C of bit 3 → PENDING bit 3 stays 1.
